// File: rtl/mem_pkg.sv
// Shared types for the LEGv8 memory stage: access FSM states and the
// control-bit bundle carried through the EX/MEM register.
package mem_pkg;

  typedef enum logic {
    IDLE,
    ACCESS
  } mem_state_t;

  typedef struct packed {
    logic valid;
    logic branch;
    logic mem_read;
    logic mem_write;
    logic reg_write;
    logic memto_reg;
  } ctrl_m_t;

  localparam int unsigned CTRL_M_W = $bits(ctrl_m_t);

endpackage : mem_pkg

// File: rtl/pipe_reg.sv
// Generic pipeline register: synchronous clear has priority over the enable.
module pipe_reg #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Clear wins; otherwise load when enabled, hold when not.
  always_ff @(posedge clk) begin
    if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule : pipe_reg

// File: rtl/memory_stage.sv
// LEGv8 memory stage: EX/MEM register, branch resolution, req/ack data
// memory access with upstream stall, and MEM/WB register.
// Optional build macro MEM_ALIGN_CHECK_EN adds misalign_M and suppresses
// memory access for addresses that are not 8-byte aligned.
module memory_stage
  import mem_pkg::*;
#(
  parameter int N     = 64,
  parameter int REG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_E,
  input  logic             Branch_E,
  input  logic             MemRead_E,
  input  logic             MemWrite_E,
  input  logic             RegWrite_E,
  input  logic             MemtoReg_E,
  input  logic [REG_W-1:0] writeReg_E,
  input  logic [N-1:0]     PCBranch_E,
  input  logic [N-1:0]     aluResult_E,
  input  logic [N-1:0]     writeData_E,
  input  logic             zero_E,
  output logic             stall_M,
  output logic             PCSrc_M,
  output logic [N-1:0]     PCBranch_M,
  output logic             dm_req,
  output logic             dm_we,
  output logic [N-1:0]     dm_addr,
  output logic [N-1:0]     dm_wdata,
  input  logic [N-1:0]     dm_rdata,
  input  logic             dm_ack,
`ifdef MEM_ALIGN_CHECK_EN
  output logic             misalign_M,
`endif
  output logic             valid_W,
  output logic             RegWrite_W,
  output logic             MemtoReg_W,
  output logic [REG_W-1:0] writeReg_W,
  output logic [N-1:0]     aluResult_W,
  output logic [N-1:0]     readData_W
);

  typedef struct packed {
    ctrl_m_t          ctrl;
    logic [REG_W-1:0] write_reg;
    logic [N-1:0]     pc_branch;
    logic [N-1:0]     alu_result;
    logic [N-1:0]     write_data;
    logic             zero;
  } m_reg_t;

  typedef struct packed {
    logic             valid;
    logic             reg_write;
    logic             memto_reg;
    logic [REG_W-1:0] write_reg;
    logic [N-1:0]     alu_result;
  } w_reg_t;

  m_reg_t     m_d, m_q;
  w_reg_t     w_d, w_q;
  mem_state_t state_d, state_q;
  logic [N-1:0] read_data_d, read_data_q;

  logic capture;
  logic e_valid;
  logic e_misalign;
  logic m_misalign;
  logic new_mem_op;

  assign stall_M    = (state_q == ACCESS) & ~dm_ack;
  assign capture    = ~stall_M;
  assign PCSrc_M    = m_q.ctrl.valid & m_q.ctrl.branch & m_q.zero;
  assign PCBranch_M = m_q.pc_branch;

  // Taken branch in M squashes whatever execute is presenting.
  assign e_valid = valid_E & ~PCSrc_M;

`ifdef MEM_ALIGN_CHECK_EN
  assign e_misalign = aluResult_E[2:0] != 3'b000;
  assign m_misalign = m_q.ctrl.valid & (m_q.ctrl.mem_read | m_q.ctrl.mem_write)
                    & (m_q.alu_result[2:0] != 3'b000);
  assign misalign_M = m_misalign;
`else
  assign e_misalign = 1'b0;
  assign m_misalign = 1'b0;
`endif

  assign new_mem_op = capture & e_valid & (MemRead_E | MemWrite_E)
                    & ~Branch_E & ~e_misalign;

  assign dm_req   = (state_q == ACCESS);
  assign dm_we    = m_q.ctrl.mem_write;
  assign dm_addr  = m_q.alu_result;
  assign dm_wdata = m_q.write_data;

  // Assemble the EX/MEM register input from execute results.
  always_comb begin
    m_d                = '0;
    m_d.ctrl.valid     = e_valid;
    m_d.ctrl.branch    = Branch_E;
    m_d.ctrl.mem_read  = MemRead_E;
    m_d.ctrl.mem_write = MemWrite_E;
    m_d.ctrl.reg_write = RegWrite_E;
    m_d.ctrl.memto_reg = MemtoReg_E;
    m_d.write_reg      = writeReg_E;
    m_d.pc_branch      = PCBranch_E;
    m_d.alu_result     = aluResult_E;
    m_d.write_data     = writeData_E;
    m_d.zero           = zero_E;
  end

  pipe_reg #(.W($bits(m_reg_t))) u_m_reg (
    .clk (clk),
    .clr (reset),
    .en  (capture),
    .d   (m_d),
    .q   (m_q)
  );

  // Access FSM: a memory op captured on the ack edge keeps the FSM in ACCESS.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (new_mem_op) state_d = ACCESS;
      ACCESS:  if (dm_ack) state_d = new_mem_op ? ACCESS : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // MEM/WB input: register always loads so that valid drops to a bubble
  // on stall edges while the payload fields hold their previous values.
  always_comb begin
    w_d       = w_q;
    w_d.valid = 1'b0;
    if (capture) begin
      w_d.valid      = m_q.ctrl.valid & ~m_q.ctrl.branch & ~m_misalign;
      w_d.reg_write  = m_q.ctrl.reg_write;
      w_d.memto_reg  = m_q.ctrl.memto_reg;
      w_d.write_reg  = m_q.write_reg;
      w_d.alu_result = m_q.alu_result;
    end
  end

  pipe_reg #(.W($bits(w_reg_t))) u_w_reg (
    .clk (clk),
    .clr (reset),
    .en  (1'b1),
    .d   (w_d),
    .q   (w_q)
  );

  // Load data is captured only when a load completes; otherwise it holds.
  always_comb begin
    read_data_d = read_data_q;
    if ((state_q == ACCESS) && m_q.ctrl.mem_read && dm_ack) begin
      read_data_d = dm_rdata;
    end
  end

  // Load data register.
  always_ff @(posedge clk) begin
    if (reset) read_data_q <= '0;
    else       read_data_q <= read_data_d;
  end

  assign valid_W     = w_q.valid;
  assign RegWrite_W  = w_q.reg_write;
  assign MemtoReg_W  = w_q.memto_reg;
  assign writeReg_W  = w_q.write_reg;
  assign aluResult_W = w_q.alu_result;
  assign readData_W  = read_data_q;

endmodule : memory_stage

// File: tb/tb_memory_stage.sv
// Directed self-checking bench for memory_stage.
module tb_memory_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_E, Branch_E, MemRead_E, MemWrite_E, RegWrite_E, MemtoReg_E;
  logic [4:0]  writeReg_E;
  logic [63:0] PCBranch_E, aluResult_E, writeData_E;
  logic        zero_E;
  logic        stall_M, PCSrc_M;
  logic [63:0] PCBranch_M;
  logic        dm_req, dm_we;
  logic [63:0] dm_addr, dm_wdata, dm_rdata;
  logic        dm_ack;
`ifdef MEM_ALIGN_CHECK_EN
  logic        misalign_M;
`endif
  logic        valid_W, RegWrite_W, MemtoReg_W;
  logic [4:0]  writeReg_W;
  logic [63:0] aluResult_W, readData_W;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  memory_stage #(.N(64), .REG_W(5)) dut (
    .clk         (clk),
    .reset       (reset),
    .valid_E     (valid_E),
    .Branch_E    (Branch_E),
    .MemRead_E   (MemRead_E),
    .MemWrite_E  (MemWrite_E),
    .RegWrite_E  (RegWrite_E),
    .MemtoReg_E  (MemtoReg_E),
    .writeReg_E  (writeReg_E),
    .PCBranch_E  (PCBranch_E),
    .aluResult_E (aluResult_E),
    .writeData_E (writeData_E),
    .zero_E      (zero_E),
    .stall_M     (stall_M),
    .PCSrc_M     (PCSrc_M),
    .PCBranch_M  (PCBranch_M),
    .dm_req      (dm_req),
    .dm_we       (dm_we),
    .dm_addr     (dm_addr),
    .dm_wdata    (dm_wdata),
    .dm_rdata    (dm_rdata),
    .dm_ack      (dm_ack),
`ifdef MEM_ALIGN_CHECK_EN
    .misalign_M  (misalign_M),
`endif
    .valid_W     (valid_W),
    .RegWrite_W  (RegWrite_W),
    .MemtoReg_W  (MemtoReg_W),
    .writeReg_W  (writeReg_W),
    .aluResult_W (aluResult_W),
    .readData_W  (readData_W)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are then changed and outputs sampled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_e(input logic v, br, mr, mw, rw, m2r,
                         input logic [4:0] wr, input logic [63:0] pcb, alu, wd,
                         input logic z);
    valid_E = v; Branch_E = br; MemRead_E = mr; MemWrite_E = mw;
    RegWrite_E = rw; MemtoReg_E = m2r; writeReg_E = wr;
    PCBranch_E = pcb; aluResult_E = alu; writeData_E = wd; zero_E = z;
  endtask

  task automatic idle_e();
    drive_e(0, 0, 0, 0, 0, 0, 5'd0, 64'h0, 64'h0, 64'h0, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; dm_ack = 1'b0; dm_rdata = '0;
    idle_e();
    tick(); tick();
    reset = 1'b0;
    #1;
    check("rst_dm_req",   dm_req,      0);
    check("rst_stall",    stall_M,     0);
    check("rst_pcsrc",    PCSrc_M,     0);
    check("rst_valid_w",  valid_W,     0);
    check("rst_alu_w",    aluResult_W, 0);
    check("rst_rdata_w",  readData_W,  0);

    // ALU op: reaches W two edges after being presented.
    drive_e(1, 0, 0, 0, 1, 0, 5'd3, 64'h0, 64'h10, 64'h0, 0);
    tick(); idle_e(); #1;
    check("alu_stall_m",  stall_M, 0);
    check("alu_no_req",   dm_req,  0);
    check("alu_valid_w_early", valid_W, 0);
    tick();
    check("alu_valid_w",  valid_W,     1);
    check("alu_result_w", aluResult_W, 64'h10);
    check("alu_regwr_w",  RegWrite_W,  1);
    check("alu_wreg_w",   writeReg_W,  3);
    check("alu_stall_w",  stall_M,     0);
    tick();
    check("alu_valid_w_once", valid_W, 0);

    // Load at 0x20, ack in the third request cycle.
    drive_e(1, 0, 1, 0, 1, 1, 5'd5, 64'h0, 64'h20, 64'h0, 0);
    tick(); idle_e(); #1;
    check("ld_req_c1",   dm_req,  1);
    check("ld_stall_c1", stall_M, 1);
    check("ld_addr",     dm_addr, 64'h20);
    check("ld_we",       dm_we,   0);
    tick();
    check("ld_req_c2",   dm_req,  1);
    check("ld_stall_c2", stall_M, 1);
    check("ld_bubble_c2", valid_W, 0);
    tick();
    dm_ack = 1'b1; dm_rdata = 64'hDEAD; #1;
    check("ld_req_c3",   dm_req,  1);
    check("ld_stall_c3", stall_M, 0);
    check("ld_bubble_c3", valid_W, 0);
    tick();
    dm_ack = 1'b0; dm_rdata = 64'h0; #1;
    check("ld_req_done", dm_req,     0);
    check("ld_valid_w",  valid_W,    1);
    check("ld_rdata_w",  readData_W, 64'hDEAD);
    check("ld_m2r_w",    MemtoReg_W, 1);
    check("ld_wreg_w",   writeReg_W, 5);
    tick();
    check("ld_valid_once", valid_W,  0);
    check("ld_rdata_hold", readData_W, 64'hDEAD);

    // Store at 0x40, zero-wait memory.
    drive_e(1, 0, 0, 1, 0, 0, 5'd0, 64'h0, 64'h40, 64'h55, 0);
    tick(); idle_e(); dm_ack = 1'b1; #1;
    check("st_req",   dm_req,   1);
    check("st_we",    dm_we,    1);
    check("st_wdata", dm_wdata, 64'h55);
    check("st_addr",  dm_addr,  64'h40);
    check("st_stall", stall_M,  0);
    tick();
    dm_ack = 1'b0; #1;
    check("st_req_done", dm_req,     0);
    check("st_valid_w",  valid_W,    1);
    check("st_regwr_w",  RegWrite_W, 0);
    check("st_rdata_keep", readData_W, 64'hDEAD);

    // Back-to-back loads: a load captured on the ack edge keeps the request up.
    drive_e(1, 0, 1, 0, 1, 1, 5'd6, 64'h0, 64'h28, 64'h0, 0);
    tick();
    drive_e(1, 0, 1, 0, 1, 1, 5'd7, 64'h0, 64'h30, 64'h0, 0);
    dm_ack = 1'b1; dm_rdata = 64'h1111; #1;
    check("b2b_stall", stall_M, 0);
    tick();
    idle_e(); dm_rdata = 64'h2222; #1;
    check("b2b_req2",   dm_req,     1);
    check("b2b_addr2",  dm_addr,    64'h30);
    check("b2b_valid1", valid_W,    1);
    check("b2b_rdata1", readData_W, 64'h1111);
    tick();
    dm_ack = 1'b0; #1;
    check("b2b_req_done", dm_req,   0);
    check("b2b_rdata2", readData_W, 64'h2222);
    check("b2b_wreg2",  writeReg_W, 7);

    // Not-taken branch.
    drive_e(1, 1, 0, 0, 0, 0, 5'd0, 64'h200, 64'h0, 64'h0, 0);
    tick(); idle_e(); #1;
    check("bnt_pcsrc", PCSrc_M, 0);
    tick();
    check("bnt_valid_w", valid_W, 0);

    // Taken branch followed by a valid instruction that must be squashed.
    drive_e(1, 1, 0, 0, 0, 0, 5'd0, 64'h100, 64'h0, 64'h0, 1);
    tick();
    drive_e(1, 0, 0, 0, 1, 0, 5'd9, 64'h0, 64'h77, 64'h0, 0); #1;
    check("br_pcsrc",  PCSrc_M,    1);
    check("br_target", PCBranch_M, 64'h100);
    tick();
    idle_e(); #1;
    check("br_pcsrc_once", PCSrc_M, 0);
    check("br_valid_w",    valid_W, 0);
    tick();
    check("br_squash_w",   valid_W, 0);
    tick();
    check("br_squash_w2",  valid_W, 0);

    // Reset while a load is waiting for ack.
    drive_e(1, 0, 1, 0, 1, 1, 5'd4, 64'h0, 64'h20, 64'h0, 0);
    tick(); idle_e(); #1;
    check("rsta_req", dm_req, 1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0; #1;
    check("rsta_req_clr",   dm_req,     0);
    check("rsta_stall_clr", stall_M,    0);
    check("rsta_valid_w",   valid_W,    0);
    check("rsta_rdata_clr", readData_W, 0);
    drive_e(1, 0, 1, 0, 1, 1, 5'd8, 64'h0, 64'h28, 64'h0, 0);
    tick(); idle_e(); #1;
    check("rsta_ld_req",   dm_req,  1);
    check("rsta_ld_stall", stall_M, 1);
    tick();
    dm_ack = 1'b1; dm_rdata = 64'hBEEF; #1;
    check("rsta_ld_ack_stall", stall_M, 0);
    tick();
    dm_ack = 1'b0; #1;
    check("rsta_ld_valid_w", valid_W,    1);
    check("rsta_ld_rdata_w", readData_W, 64'hBEEF);

    // Stray ack with no request outstanding has no effect.
    dm_ack = 1'b1; dm_rdata = 64'hFFFF; #1;
    check("stray_ack_stall", stall_M, 0);
    tick();
    dm_ack = 1'b0; #1;
    check("stray_ack_rdata", readData_W, 64'hBEEF);

`ifdef MEM_ALIGN_CHECK_EN
    // Misaligned load never reaches memory or writeback.
    drive_e(1, 0, 1, 0, 1, 1, 5'd2, 64'h0, 64'h13, 64'h0, 0);
    tick(); idle_e(); #1;
    check("mis_flag",  misalign_M, 1);
    check("mis_req",   dm_req,     0);
    check("mis_stall", stall_M,    0);
    tick();
    check("mis_valid_w",   valid_W,    0);
    check("mis_flag_once", misalign_M, 0);
    check("mis_req_after", dm_req,     0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_memory_stage
